// File: rtl/caesar_clk_gate_ctrl.sv
// caesar_clk_gate_ctrl: activity-driven clock-gate enable with settle-then-grant wake and gating-event counter
module caesar_clk_gate_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cfg_auto_gate_i,
   input  logic             cfg_force_on_i,
   input  logic             test_mode_i,
   input  logic             req_i,
   input  logic             busy_i,
   input  logic             cnt_clr_i,
   output logic             clk_en_o,
   output logic             gnt_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] gate_cnt_o
);
   localparam int IW = IDLE_CYCLES > 1 ? $clog2(IDLE_CYCLES) : 1;
   localparam int WW = WAKE_CYCLES > 1 ? $clog2(WAKE_CYCLES) : 1;
   typedef enum logic [1:0] {RUN = 2'd0, OFF = 2'd1, WAKE = 2'd2} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] idle_cnt_q, idle_cnt_d;
   logic [WW-1:0] wake_cnt_q, wake_cnt_d;
   logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
   logic keep_on, active, idle_done, wake_done, gate_evt;
   assign keep_on   = !cfg_auto_gate_i | cfg_force_on_i | test_mode_i;
   assign active    = req_i | busy_i | keep_on;
   assign idle_done = idle_cnt_q == IW'(IDLE_CYCLES - 1);
   assign wake_done = wake_cnt_q == WW'(WAKE_CYCLES - 1);
   assign gate_evt  = state_q == RUN && !active && idle_done;
   // next state and counters; WAKE ignores inputs and always runs to completion
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      case (state_q)
         RUN: begin
            idle_cnt_d = active ? '0 : idle_cnt_q + 1'b1;
            state_d    = gate_evt ? OFF : RUN;
         end
         OFF: begin
            state_d    = active ? WAKE : OFF;
            wake_cnt_d = active ? '0 : wake_cnt_q;
         end
         WAKE: begin
            state_d    = wake_done ? RUN : WAKE;
            wake_cnt_d = wake_done ? wake_cnt_q : wake_cnt_q + 1'b1;
            idle_cnt_d = wake_done ? '0 : idle_cnt_q;
         end
         default: state_d = RUN;
      endcase
      gate_cnt_d = cnt_clr_i ? '0 : (gate_evt && gate_cnt_q != '1) ? gate_cnt_q + 1'b1 : gate_cnt_q;
   end
   // state and counter registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= RUN;
         idle_cnt_q <= '0;
         wake_cnt_q <= '0;
         gate_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         wake_cnt_q <= wake_cnt_d;
         gate_cnt_q <= gate_cnt_d;
      end
   end
   assign clk_en_o   = state_q != OFF;
   assign gnt_o      = state_q == RUN;
   assign state_o    = state_q;
   assign gate_cnt_o = gate_cnt_q;
endmodule

// File: tb/tb_caesar_clk_gate_ctrl.sv
// tb_caesar_clk_gate_ctrl: directed checks of gating, wake, keep-on, reset and counter behaviour
module tb_caesar_clk_gate_ctrl;
   logic clk = 0, rst = 1, auto_g = 0, force_on = 0, tmode = 0, req = 0, busy = 0, clr = 0;
   logic clk_en, gnt;
   logic [1:0] st;
   logic [1:0] gcnt;
   int vecs = 0, errs = 0;
   caesar_clk_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2), .CNT_W(2)) dut (
      .clk_i(clk), .rst_i(rst), .cfg_auto_gate_i(auto_g), .cfg_force_on_i(force_on),
      .test_mode_i(tmode), .req_i(req), .busy_i(busy), .cnt_clr_i(clr),
      .clk_en_o(clk_en), .gnt_o(gnt), .state_o(st), .gate_cnt_o(gcnt)
   );
   always #5 clk = ~clk;
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wake_to_run();
      busy = 1;
      step();
      busy = 0;
      step(2);
   endtask
   task automatic test_reset();
      rst = 1;
      step();
      vecs++;
      if ({st, clk_en, gnt, gcnt} !== {2'd0, 1'b1, 1'b1, 2'd0}) begin
         errs++;
         $display("FAIL reset: st=%0d en=%b gnt=%b cnt=%0d want 0 1 1 0", st, clk_en, gnt, gcnt);
      end
      rst = 0;
   endtask
   task automatic test_auto_gate();
      auto_g = 1;
      step(15);
      vecs++;
      if (clk_en !== 1'b1) begin errs++; $display("FAIL gate_early: en=%b want 1", clk_en); end
      step();
      vecs++;
      if ({st, clk_en, gnt, gcnt} !== {2'd1, 1'b0, 1'b0, 2'd1}) begin
         errs++;
         $display("FAIL gate16: st=%0d en=%b gnt=%b cnt=%0d want 1 0 0 1", st, clk_en, gnt, gcnt);
      end
   endtask
   task automatic test_wake_grant();
      req = 1;
      step();
      vecs++;
      if ({st, clk_en, gnt} !== {2'd2, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL wake_t: st=%0d en=%b gnt=%b want 2 1 0", st, clk_en, gnt);
      end
      step();
      vecs++;
      if (gnt !== 1'b0) begin errs++; $display("FAIL wake_t1: gnt=%b want 0", gnt); end
      step();
      vecs++;
      if ({st, gnt} !== {2'd0, 1'b1}) begin
         errs++;
         $display("FAIL wake_t2: st=%0d gnt=%b want 0 1", st, gnt);
      end
      req = 0;
      step(15);
      vecs++;
      if (st !== 2'd0) begin errs++; $display("FAIL regate_early: st=%0d want 0", st); end
      step();
      vecs++;
      if ({st, gcnt} !== {2'd1, 2'd2}) begin
         errs++;
         $display("FAIL regate: st=%0d cnt=%0d want 1 2", st, gcnt);
      end
   endtask
   task automatic test_dropped_req();
      req = 1;
      step();
      req = 0;
      auto_g = 1;
      step(2);
      vecs++;
      if ({st, gnt} !== {2'd0, 1'b1}) begin
         errs++;
         $display("FAIL drop_req: st=%0d gnt=%b want 0 1", st, gnt);
      end
      step(16);
      vecs++;
      if ({st, gcnt} !== {2'd1, 2'd3}) begin
         errs++;
         $display("FAIL drop_regate: st=%0d cnt=%0d want 1 3", st, gcnt);
      end
   endtask
   task automatic test_req_at_threshold();
      rst = 1;
      step();
      rst = 0;
      step(16);
      wake_to_run();
      step(15);
      req = 1;
      step();
      req = 0;
      vecs++;
      if ({st, gcnt} !== {2'd0, 2'd1}) begin
         errs++;
         $display("FAIL thresh: st=%0d cnt=%0d want 0 1", st, gcnt);
      end
      step(15);
      vecs++;
      if (st !== 2'd0) begin errs++; $display("FAIL thresh_idle0: st=%0d want 0", st); end
      step();
      vecs++;
      if ({st, gcnt} !== {2'd1, 2'd2}) begin
         errs++;
         $display("FAIL thresh_gate: st=%0d cnt=%0d want 1 2", st, gcnt);
      end
   endtask
   task automatic test_keep_on();
      int bad = 0;
      tmode = 1;
      step();
      vecs++;
      if ({st, clk_en} !== {2'd2, 1'b1}) begin
         errs++;
         $display("FAIL tmode_wake: st=%0d en=%b want 2 1", st, clk_en);
      end
      step(2);
      vecs++;
      if ({st, gnt} !== {2'd0, 1'b1}) begin
         errs++;
         $display("FAIL tmode_run: st=%0d gnt=%b want 0 1", st, gnt);
      end
      tmode = 0;
      force_on = 1;
      for (int i = 0; i < 100; i++) begin step(); bad += (clk_en !== 1'b1); end
      force_on = 0;
      auto_g = 0;
      for (int i = 0; i < 100; i++) begin step(); bad += (clk_en !== 1'b1); end
      auto_g = 1;
      vecs++;
      if (bad != 0) begin errs++; $display("FAIL keep_on: %0d cycles en=0 want 0", bad); end
   endtask
   task automatic test_reset_in_wake();
      step(16);
      vecs++;
      if ({st, gcnt} !== {2'd1, 2'd3}) begin
         errs++;
         $display("FAIL pre_rst: st=%0d cnt=%0d want 1 3", st, gcnt);
      end
      req = 1;
      step();
      rst = 1;
      step();
      rst = 0;
      req = 0;
      vecs++;
      if ({st, gnt, clk_en, gcnt} !== {2'd0, 1'b1, 1'b1, 2'd0}) begin
         errs++;
         $display("FAIL rst_wake: st=%0d gnt=%b en=%b cnt=%0d want 0 1 1 0", st, gnt, clk_en, gcnt);
      end
   endtask
   task automatic test_saturate_clear();
      logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
         step(16);
         vecs++;
         if ({st, gcnt} !== {2'd1, exp_c[i]}) begin
            errs++;
            $display("FAIL sat%0d: st=%0d cnt=%0d want 1 %0d", i, st, gcnt, exp_c[i]);
         end
         wake_to_run();
      end
      step(15);
      clr = 1;
      step();
      clr = 0;
      vecs++;
      if ({st, gcnt} !== {2'd1, 2'd0}) begin
         errs++;
         $display("FAIL clr_vs_inc: st=%0d cnt=%0d want 1 0", st, gcnt);
      end
   endtask
   initial begin
      test_reset();
      test_auto_gate();
      test_wake_grant();
      test_dropped_req();
      test_req_at_threshold();
      test_keep_on();
      test_reset_in_wake();
      test_saturate_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
